// File: rtl/vgasoc_pkg.sv
// Shared VGASOC definitions: default bus widths, slot indices and a one-hot check.
package vgasoc_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam int unsigned SLOT_VGA = 0;
    localparam int unsigned SLOT_CPU = 1;
    localparam int unsigned SLOT_AUX = 2;

    // Vectors narrower than 32 bits are zero-extended by the caller.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/tag_pipe.sv
// Read-tag delay line: DEPTH stages of one-hot slot tags, cleared asynchronously.
module tag_pipe #(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] tag_i,
    output logic [NUM_SLOTS-1:0] tag_o
);

    logic [NUM_SLOTS-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/slot_arbiter.sv
// TDM memory arbiter driven by a one-hot phase vector; one registered command per cycle.
// Define SLOT_ARBITER_STEAL_EN to let an idle slot be granted to the lowest-index requester.
module slot_arbiter
    import vgasoc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 3,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SLOTS-1:0]            phase,
    input  logic [NUM_SLOTS-1:0]            req,
    input  logic [NUM_SLOTS-1:0]            we,
    input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_SLOTS-1:0]            ack,
    output logic [NUM_SLOTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            phase_err
);

    localparam int unsigned IdxW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                  phase_ok;
    logic [NUM_SLOTS-1:0]  grant;
    logic [IdxW-1:0]       gidx;
    logic [NUM_SLOTS-1:0]  tag_exit;

    logic [NUM_SLOTS-1:0]  ack_d, ack_q;
    logic [NUM_SLOTS-1:0]  rvalid_d, rvalid_q;
    logic [NUM_SLOTS-1:0]  rd_tag_d, rd_tag_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic                  mem_en_d, mem_en_q;
    logic                  mem_we_d, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_d, mem_wdata_q;
    logic                  phase_err_d, phase_err_q;

    always_comb begin
        phase_ok = is_onehot(32'(phase));
        grant    = '0;
        if (phase_ok) begin
            grant = phase & req;
`ifdef SLOT_ARBITER_STEAL_EN
            // Owner idle: the first requester found from index 0 upward takes the slot.
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (req[j] && (grant == '0)) begin
                    grant[j] = 1'b1;
                end
            end
`endif
        end
        gidx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (grant[i]) begin
                gidx = IdxW'(i);
            end
        end
    end

    always_comb begin
        ack_d       = grant;
        mem_en_d    = |grant;
        mem_we_d    = (|grant) & we[gidx];
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (|grant) begin
            mem_addr_d  = addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_d = wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
        end
        rd_tag_d    = ((|grant) && !we[gidx]) ? grant : '0;
        rvalid_d    = tag_exit;
        rdata_d     = (|tag_exit) ? mem_rdata : rdata_q;
        phase_err_d = phase_err_q | ~phase_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q       <= '0;
            rvalid_q    <= '0;
            rd_tag_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            phase_err_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            rd_tag_q    <= rd_tag_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            phase_err_q <= phase_err_d;
        end
    end

    // Tag enters alongside mem_en and exits in the cycle mem_rdata is valid.
    tag_pipe #(
        .NUM_SLOTS (NUM_SLOTS),
        .DEPTH     (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (rd_tag_q),
        .tag_o (tag_exit)
    );

    assign ack       = ack_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign phase_err = phase_err_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter with a two-cycle-latency memory model.
module tb_slot_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  phase;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [2:0]  ack;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        phase_err;

    int n_vec = 0;
    int n_err = 0;

    slot_arbiter #(
        .NUM_SLOTS  (3),
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .RD_LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .phase_err (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: samples the command at the edge after mem_en, data valid two cycles on.
    logic [7:0] mem [0:65535];
    logic       rd1_v, rd2_v;
    logic [7:0] rd1_d, rd2_d;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0010] = 8'h11;
        mem[16'h0020] = 8'h22;
        mem[16'h0030] = 8'h33;
        rd1_v = 1'b0;
        rd2_v = 1'b0;
        rd1_d = 8'h00;
        rd2_d = 8'h00;
    end

    always @(posedge clk) begin
        rd1_v <= mem_en && !mem_we;
        rd1_d <= mem[mem_addr];
        rd2_v <= rd1_v;
        rd2_d <= rd1_d;
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = rd2_v ? rd2_d : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [2:0] ph, input logic [2:0] rq, input logic [2:0] w);
        phase = ph;
        req   = rq;
        we    = w;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_phase_err"}, 32'(phase_err), 32'h0);
        chk({tag, "_rdata"}, 32'(rdata), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        rst   = 1'b0;
        phase = 3'b001;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        tick(3'b001, 3'b000, 3'b000);
        chk("idle_phase_err", 32'(phase_err), 32'h0);
        chk("idle_mem_en", 32'(mem_en), 32'h0);

        // Single CPU read
        addr[16 +: 16] = 16'h1234;
        tick(3'b010, 3'b010, 3'b000);
        chk("rd1_mem_en", 32'(mem_en), 32'h1);
        chk("rd1_mem_we", 32'(mem_we), 32'h0);
        chk("rd1_mem_addr", 32'(mem_addr), 32'h1234);
        chk("rd1_ack", 32'(ack), 32'h2);
        tick(3'b100, 3'b000, 3'b000);
        chk("rd1_idle_en", 32'(mem_en), 32'h0);
        chk("rd1_ack_pulse", 32'(ack), 32'h0);
        chk("rd1_addr_hold", 32'(mem_addr), 32'h1234);
        chk("rd1_rv_early1", 32'(rvalid), 32'h0);
        tick(3'b001, 3'b000, 3'b000);
        chk("rd1_rv_early2", 32'(rvalid), 32'h0);
        tick(3'b010, 3'b000, 3'b000);
        chk("rd1_rvalid", 32'(rvalid), 32'h2);
        chk("rd1_rdata", 32'(rdata), 32'hA5);
        tick(3'b100, 3'b000, 3'b000);
        chk("rd1_rv_pulse", 32'(rvalid), 32'h0);
        chk("rd1_rdata_hold", 32'(rdata), 32'hA5);

        // Three back-to-back reads
        addr[0 +: 16]  = 16'h0010;
        addr[16 +: 16] = 16'h0020;
        addr[32 +: 16] = 16'h0030;
        tick(3'b001, 3'b001, 3'b000);
        chk("b2b_ack0", 32'(ack), 32'h1);
        chk("b2b_addr0", 32'(mem_addr), 32'h0010);
        chk("b2b_en0", 32'(mem_en), 32'h1);
        tick(3'b010, 3'b010, 3'b000);
        chk("b2b_ack1", 32'(ack), 32'h2);
        chk("b2b_addr1", 32'(mem_addr), 32'h0020);
        tick(3'b100, 3'b100, 3'b000);
        chk("b2b_ack2", 32'(ack), 32'h4);
        chk("b2b_addr2", 32'(mem_addr), 32'h0030);
        tick(3'b001, 3'b000, 3'b000);
        chk("b2b_idle_en", 32'(mem_en), 32'h0);
        chk("b2b_rv0", 32'(rvalid), 32'h1);
        chk("b2b_rd0", 32'(rdata), 32'h11);
        tick(3'b010, 3'b000, 3'b000);
        chk("b2b_rv1", 32'(rvalid), 32'h2);
        chk("b2b_rd1", 32'(rdata), 32'h22);
        tick(3'b100, 3'b000, 3'b000);
        chk("b2b_rv2", 32'(rvalid), 32'h4);
        chk("b2b_rd2", 32'(rdata), 32'h33);
        tick(3'b001, 3'b000, 3'b000);
        chk("b2b_rv_end", 32'(rvalid), 32'h0);
        chk("b2b_rd_hold", 32'(rdata), 32'h33);

        // Slot 2 write, then slot 0 reads it back
        addr[32 +: 16] = 16'h0100;
        wdata[16 +: 8] = 8'h5A;
        tick(3'b010, 3'b000, 3'b000);
        chk("wr_pre_en", 32'(mem_en), 32'h0);
        tick(3'b100, 3'b100, 3'b100);
        chk("wr_en", 32'(mem_en), 32'h1);
        chk("wr_we", 32'(mem_we), 32'h1);
        chk("wr_addr", 32'(mem_addr), 32'h0100);
        chk("wr_wdata", 32'(mem_wdata), 32'h5A);
        chk("wr_ack", 32'(ack), 32'h4);
        addr[0 +: 16] = 16'h0100;
        tick(3'b001, 3'b001, 3'b000);
        chk("rb_en", 32'(mem_en), 32'h1);
        chk("rb_we", 32'(mem_we), 32'h0);
        chk("rb_ack", 32'(ack), 32'h1);
        tick(3'b010, 3'b000, 3'b000);
        chk("rb_idle_we", 32'(mem_we), 32'h0);
        tick(3'b100, 3'b000, 3'b000);
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        tick(3'b001, 3'b000, 3'b000);
        chk("rb_rvalid", 32'(rvalid), 32'h1);
        chk("rb_rdata", 32'(rdata), 32'h5A);

        // Slot 2 requests outside its slot, then drops before it comes round
        tick(3'b010, 3'b000, 3'b000);
        chk("pre_steal_rv", 32'(rvalid), 32'h0);
        tick(3'b100, 3'b000, 3'b000);
        tick(3'b001, 3'b100, 3'b000);
`ifdef SLOT_ARBITER_STEAL_EN
        chk("steal_ack", 32'(ack), 32'h4);
        chk("steal_en", 32'(mem_en), 32'h1);
`else
        chk("strict_ack", 32'(ack), 32'h0);
        chk("strict_en", 32'(mem_en), 32'h0);
`endif
        tick(3'b010, 3'b000, 3'b000);
        chk("cancel_ack1", 32'(ack), 32'h0);
        tick(3'b100, 3'b000, 3'b000);
        chk("cancel_ack2", 32'(ack), 32'h0);
        chk("pre_err", 32'(phase_err), 32'h0);

        // Two-hot phase
        tick(3'b011, 3'b111, 3'b000);
        chk("bad_ph_en", 32'(mem_en), 32'h0);
        chk("bad_ph_ack", 32'(ack), 32'h0);
        chk("bad_ph_err", 32'(phase_err), 32'h1);
        tick(3'b100, 3'b000, 3'b000);
        chk("err_sticky1", 32'(phase_err), 32'h1);
        tick(3'b001, 3'b000, 3'b000);
        chk("err_sticky2", 32'(phase_err), 32'h1);

        // Reset one cycle after a read command
        addr[16 +: 16] = 16'h0020;
        tick(3'b010, 3'b010, 3'b000);
        chk("rst_pre_en", 32'(mem_en), 32'h1);
        chk("rst_pre_ack", 32'(ack), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        phase = 3'b100;
        req   = 3'b000;
        rst   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick((k % 3 == 0) ? 3'b100 : ((k % 3 == 1) ? 3'b001 : 3'b010), 3'b000, 3'b000);
            chk("post_rst_rvalid", 32'(rvalid), 32'h0);
            chk("post_rst_rdata", 32'(rdata), 32'h0);
            chk("post_rst_err", 32'(phase_err), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
